// File: rtl/mem_pkg.sv
// Shared funct3 codes and FSM state encoding for the multi-cycle data memory.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

endpackage

// File: rtl/mem_align.sv
// Combinational RV32I sub-word steering: store byte enables and lane data,
// load lane extraction with sign/zero extension, and access legality.
module mem_align
  import mem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic        req_write,
  input  logic [31:0] din,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_val,
  output logic        err
);

  logic [31:0] shifted;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Aligned halves only ever shift by 0 or 16, so one barrel shift serves both widths.
  assign shifted = rdata >> {addr_lo, 3'b000};
  assign byte_v  = shifted[7:0];
  assign half_v  = shifted[15:0];

  always_comb begin
    be       = 4'b0000;
    wdata    = din;
    load_val = 32'h0;
    err      = 1'b0;
    case (funct3)
      F3_B: begin
        be       = 4'b0001 << addr_lo;
        wdata    = {4{din[7:0]}};
        load_val = {{24{byte_v[7]}}, byte_v};
      end
      F3_H: begin
        err      = addr_lo[0];
        be       = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata    = {2{din[15:0]}};
        load_val = {{16{half_v[15]}}, half_v};
      end
      F3_W: begin
        err      = (addr_lo != 2'b00);
        be       = 4'b1111;
        load_val = rdata;
      end
      F3_BU: begin
        err      = req_write;
        load_val = {24'h0, byte_v};
      end
      F3_HU: begin
        err      = req_write | addr_lo[0];
        load_val = {16'h0, half_v};
      end
      default: err = 1'b1;
    endcase
    if (err) be = 4'b0000;
  end

endmodule

// File: rtl/data_memory_mc.sv
// Multi-cycle byte-addressable data memory with request/response handshake,
// configurable access latency and RV32I sub-word loads/stores.
module data_memory_mc
  import mem_pkg::*;
#(
  parameter int MEM_DEPTH = 16384,
  parameter int LATENCY   = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] din,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] dout
);

  localparam int AW = $clog2(MEM_DEPTH);
  localparam int CW = $clog2(LATENCY + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

  state_t state, state_next;
  logic [CW-1:0] cnt;

  logic          write_q;
  logic [2:0]    funct3_q;
  logic [AW+1:0] addr_q;
  logic [31:0]   din_q;

  logic [31:0] mem [MEM_DEPTH];
  logic [AW-1:0] idx;
  logic [31:0] rdata;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [31:0] load_val;
  logic        err;
  logic        fire;
  logic        accept;

  // Address bits above the array size wrap away by design.
  logic unused_addr_bits;
  assign unused_addr_bits = ^addr[31:AW+2];

  assign idx    = addr_q[AW+1:2];
  assign rdata  = mem[idx];
  assign accept = (state == IDLE) && req_valid;
  assign fire   = (state == BUSY) && (cnt == '0);
  assign req_ready = (state == IDLE) && !reset;

  mem_align u_align (
    .funct3   (funct3_q),
    .addr_lo  (addr_q[1:0]),
    .req_write(write_q),
    .din      (din_q),
    .rdata    (rdata),
    .be       (be),
    .wdata    (wdata),
    .load_val (load_val),
    .err      (err)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req_valid) state_next = BUSY;
      BUSY:    if (cnt == '0) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request capture: inputs are free to change once the request is accepted.
  always_ff @(posedge clk) begin
    if (accept) begin
      write_q  <= req_write;
      funct3_q <= funct3;
      addr_q   <= addr[AW+1:0];
      din_q    <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= '0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      dout       <= 32'h0;
    end else begin
      resp_valid <= fire;
      resp_err   <= fire && err;
      if (accept)
        cnt <= CNT_INIT;
      else if (state == BUSY && cnt != '0)
        cnt <= cnt - 1'b1;
      if (fire)
        dout <= (err || write_q) ? 32'h0 : load_val;
    end
  end

  // Reset clears the whole array; a store only commits on its final BUSY edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= 32'h0;
    end else if (fire && write_q) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

endmodule

// File: tb/tb_data_memory_mc.sv
// Self-checking bench for data_memory_mc: directed sub-word, error, wrap,
// reset and back-to-back cases plus randomized accesses against a byte-level model.
module tb_data_memory_mc;

  localparam int DEPTH = 16;
  localparam int LAT   = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] din;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] dout;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] ref_mem [DEPTH];

  data_memory_mc #(.MEM_DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .funct3    (funct3),
    .addr      (addr),
    .din       (din),
    .resp_valid(resp_valid),
    .resp_err  (resp_err),
    .dout      (dout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Behavioural model: byte-granular memory, lanes computed from size and offset.
  task automatic model_access(input logic w, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] d, output logic exp_err,
                              output logic [31:0] exp_dout);
    int size, off, idx;
    bit sgn, legal;
    logic [31:0] word, mask;
    size = 4; sgn = 0; legal = 1;
    case (f3)
      3'd0: begin size = 1; sgn = 1; end
      3'd1: begin size = 2; sgn = 1; end
      3'd2: size = 4;
      3'd4: begin size = 1; legal = !w; end
      3'd5: begin size = 2; legal = !w; end
      default: legal = 0;
    endcase
    off = int'(a[1:0]);
    idx = int'((a >> 2) % 32'(DEPTH));
    exp_err = !legal || (off % size != 0);
    exp_dout = 32'h0;
    if (!exp_err) begin
      if (w) begin
        for (int i = 0; i < size; i++) ref_mem[idx][8*(off+i) +: 8] = d[8*i +: 8];
      end else begin
        word = ref_mem[idx] >> (8 * off);
        mask = (size == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * size)) - 32'h1);
        exp_dout = word & mask;
        if (sgn && size < 4 && exp_dout[8*size-1]) exp_dout = exp_dout | ~mask;
      end
    end
  endtask

  task automatic access(input logic w, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d, input string tag, output logic [31:0] got);
    logic exp_err;
    logic [31:0] exp_dout;
    int t, lat;
    bit ready_seen;
    model_access(w, f3, a, d, exp_err, exp_dout);
    t = 0;
    while (!req_ready && t < 20) begin tick(); t++; end
    check({tag, ".ready"}, {31'h0, req_ready}, 32'h1);
    req_valid = 1'b1; req_write = w; funct3 = f3; addr = a; din = d;
    tick();
    req_valid = 1'b0; req_write = 1'($urandom); funct3 = 3'($urandom);
    addr = $urandom; din = $urandom;
    lat = 0; ready_seen = 0;
    while (!resp_valid && lat < 20) begin
      if (req_ready) ready_seen = 1;
      tick(); lat++;
    end
    if (req_ready) ready_seen = 1;
    check({tag, ".latency"}, 32'(lat), 32'(LAT));
    check({tag, ".ready_low"}, {31'h0, ready_seen}, 32'h0);
    check({tag, ".err"}, {31'h0, resp_err}, {31'h0, exp_err});
    check({tag, ".dout"}, dout, exp_dout);
    got = dout;
    tick();
    check({tag, ".pulse"}, {31'h0, resp_valid}, 32'h0);
    check({tag, ".ready_back"}, {31'h0, req_ready}, 32'h1);
  endtask

  initial begin
    logic [31:0] got;
    int accepts[$];
    int pulses;
    bit seen;

    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; funct3 = 3'b0; addr = 32'h0; din = 32'h0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;
    tick(); tick();
    check("rst.ready", {31'h0, req_ready}, 32'h0);
    check("rst.valid", {31'h0, resp_valid}, 32'h0);
    check("rst.err", {31'h0, resp_err}, 32'h0);
    check("rst.dout", dout, 32'h0);
    reset = 1'b0;
    #1;
    check("rst.ready_after", {31'h0, req_ready}, 32'h1);

    access(1, 3'b010, 32'h100, 32'hDEADBEEF, "sw100", got);
    access(0, 3'b010, 32'h100, 32'h0, "lw100", got);
    check("lw100.lit", got, 32'hDEADBEEF);
    access(1, 3'b000, 32'h102, 32'h1234567F, "sb102", got);
    access(0, 3'b010, 32'h100, 32'h0, "lw100b", got);
    check("lw100b.lit", got, 32'hDE7FBEEF);
    access(0, 3'b000, 32'h103, 32'h0, "lb103", got);
    check("lb103.lit", got, 32'hFFFFFFDE);
    access(0, 3'b100, 32'h103, 32'h0, "lbu103", got);
    check("lbu103.lit", got, 32'h000000DE);
    access(0, 3'b001, 32'h102, 32'h0, "lh102", got);
    check("lh102.lit", got, 32'hFFFFDE7F);
    access(0, 3'b101, 32'h102, 32'h0, "lhu102", got);
    check("lhu102.lit", got, 32'h0000DE7F);
    access(1, 3'b001, 32'h101, 32'hAAAA5555, "sh101", got);
    access(0, 3'b010, 32'h102, 32'h0, "lw102", got);
    access(1, 3'b100, 32'h100, 32'h11223344, "sbu100", got);
    access(0, 3'b010, 32'h100, 32'h0, "lw100c", got);
    check("lw100c.lit", got, 32'hDE7FBEEF);
    access(1, 3'b010, 32'h40, 32'h11, "sw40", got);
    access(0, 3'b010, 32'h0, 32'h0, "lw0wrap", got);
    check("lw0wrap.lit", got, 32'h00000011);

    for (int n = 0; n < 60; n++) begin
      logic [2:0] f3;
      f3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) begin
        case ($urandom_range(0, 4))
          0: f3 = 3'b000; 1: f3 = 3'b001; 2: f3 = 3'b010; 3: f3 = 3'b100; default: f3 = 3'b101;
        endcase
      end
      access(1'($urandom_range(0, 1)), f3, 32'($urandom_range(0, 255)), $urandom, "rand", got);
    end

    // req_valid held high: one acceptance every LAT+2 cycles, others ignored.
    req_valid = 1'b1; req_write = 1'b0; funct3 = 3'b010; addr = 32'h0;
    pulses = 0;
    for (int c = 0; c < 30; c++) begin
      if (req_ready) accepts.push_back(c);
      if (resp_valid) begin
        pulses++;
        check("hold.dout", dout, ref_mem[0]);
      end
      tick();
    end
    req_valid = 1'b0;
    check("hold.accepts", 32'(accepts.size()), 32'd6);
    check("hold.pulses", 32'(pulses), 32'd6);
    for (int i = 1; i < accepts.size(); i++)
      check("hold.gap", 32'(accepts[i] - accepts[i-1]), 32'(LAT + 2));

    // Reset during BUSY of a pending store, with dout left non-zero beforehand.
    access(1, 3'b010, 32'h0, 32'hA5A50001, "swpre", got);
    access(0, 3'b010, 32'h0, 32'h0, "lwpre", got);
    req_valid = 1'b1; req_write = 1'b1; funct3 = 3'b010; addr = 32'h8; din = 32'h55;
    tick();
    req_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    check("midrst.ready", {31'h0, req_ready}, 32'h0);
    check("midrst.valid", {31'h0, resp_valid}, 32'h0);
    check("midrst.err", {31'h0, resp_err}, 32'h0);
    check("midrst.dout", dout, 32'h0);
    tick();
    check("midrst.valid2", {31'h0, resp_valid}, 32'h0);
    reset = 1'b0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;
    #1;
    check("midrst.ready_after", {31'h0, req_ready}, 32'h1);
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      if (resp_valid) seen = 1;
      tick();
    end
    check("midrst.no_resp", {31'h0, seen}, 32'h0);
    access(0, 3'b010, 32'h8, 32'h0, "lw8post", got);
    check("lw8post.lit", got, 32'h0);
    access(0, 3'b010, 32'h0, 32'h0, "lw0post", got);
    check("lw0post.lit", got, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
